// File: rtl/y_result_packer_pkg.sv
// rtl/y_result_packer_pkg.sv - shared constants for the result packer
// Purpose: saturation bounds, bytes per packed word, FSM state encodings and
//          a lane-placement helper used by the packer top level.
// Ports:   none (package).
package y_result_packer_pkg;

  localparam logic [7:0] SAT_LO     = 8'h00;
  localparam logic [7:0] SAT_HI     = 8'hFF;
  localparam int         WORD_BYTES = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Lane 0 is the most significant byte of the word.
  function automatic logic [31:0] place_lane(input logic [7:0] px, input logic [1:0] lane);
    case (lane)
      2'd0:    return {px, 24'h000000};
      2'd1:    return {8'h00, px, 16'h0000};
      2'd2:    return {16'h0000, px, 8'h00};
      default: return {24'h000000, px};
    endcase
  endfunction

endpackage

// File: rtl/y_word_fifo.sv
// rtl/y_word_fifo.sv - synchronous FIFO for packed {addr, data} words
// Purpose: small power-of-two FIFO; push and pop may happen in the same cycle.
// Ports:   clk, rst (async, active-high); push/push_data write side;
//          pop/pop_data read side (pop_data shows the head entry);
//          full/empty occupancy flags.
module y_word_fifo #(
  parameter int W     = 45,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the head slot on the same edge, so a push into a full FIFO
  // is accepted when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/y_result_packer.sv
// rtl/y_result_packer.sv - saturating 4-pixel-per-word result packer
// Purpose: accepts signed ALU results, saturates to 8 bits, packs four pixels
//          MSB-first per 32-bit word (closing early at row end), queues
//          {addr, data} words and drives them out with incrementing addresses.
// Ports:   clk, rst (async, active-high); start/base_addr frame kick-off;
//          res_valid/res_data/res_ready pixel input; wr_valid/wr_ready/
//          wr_data/wr_addr word output; busy and frame_done status.
module y_result_packer import y_result_packer_pkg::*; #(
  parameter int ADDR_W     = 13,
  parameter int RES_W      = 20,
  parameter int ROW_PIX    = 28,
  parameter int ROWS       = 28,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_data,
  output logic              res_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              frame_done
);

  localparam int PIX_W = $clog2(ROW_PIX + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int FW    = 32 + ADDR_W;

  logic [1:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;

  logic [7:0]  sat_px;
  logic [31:0] word_next;
  logic        last_pix, last_row, closes, accept, push;
  logic        fifo_full, fifo_empty;
  logic [FW-1:0] fifo_rdata;

  // Negative -> 0; any magnitude bit above bit 7 set -> 255.
  always_comb begin
    sat_px = res_data[7:0];
    if (res_data[RES_W-1])            sat_px = SAT_LO;
    else if (|res_data[RES_W-2:8])    sat_px = SAT_HI;
  end

  assign last_pix  = (pix_q == PIX_W'(ROW_PIX - 1));
  assign last_row  = (row_q == ROW_W'(ROWS - 1));
  assign closes    = last_pix | (lane_q == 2'(WORD_BYTES - 1));
  // Only a word-closing pixel needs a free FIFO slot; earlier lanes just
  // accumulate in word_q.
  assign res_ready = (state_q == ST_RUN) & ~(fifo_full & closes);
  assign accept    = res_valid & res_ready;
  assign push      = accept & closes;
  assign word_next = word_q | place_lane(sat_px, lane_q);

  assign wr_valid   = ~fifo_empty;
  assign wr_addr    = fifo_rdata[FW-1:32];
  assign wr_data    = fifo_rdata[31:0];
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pix_d   = pix_q;
    row_d   = row_q;
    addr_d  = addr_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = base_addr & ~ADDR_W'(3);
          lane_d  = '0;
          pix_d   = '0;
          row_d   = '0;
          word_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (closes) begin
            word_d = '0;
            lane_d = '0;
            addr_d = addr_q + ADDR_W'(WORD_BYTES);
          end else begin
            word_d = word_next;
            lane_d = lane_q + 2'd1;
          end
          if (last_pix) begin
            pix_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      pix_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  y_word_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({addr_q, word_next}),
    .pop       (wr_ready & ~fifo_empty),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
